// File: rtl/layer2_output_serializer.sv
// Feature-link transmit serializer: splits each wide accumulator word into
// BEATS output beats, with optional per-lane ReLU and frame TLAST marking.
module layer2_output_serializer #(
    parameter int unsigned IN_W            = 512,
    parameter int unsigned OUT_W           = 64,
    parameter int unsigned BEATS           = 8,
    parameter int unsigned LANE_W          = 16,
    parameter int unsigned WORDS_PER_FRAME = 128,
    parameter int unsigned RELU_EN         = 0
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [IN_W-1:0]   d_Data_TDATA,
    input  logic              d_Data_TVALID,
    output logic              d_Data_TREADY,
    output logic [OUT_W-1:0]  feature_TDATA,
    output logic              feature_TVALID,
    input  logic              feature_TREADY,
    output logic              feature_TLAST
);

    localparam int unsigned LANES   = IN_W / LANE_W;
    localparam int unsigned BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WORD_CW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

    generate
        if (IN_W != OUT_W * BEATS) begin : g_bad_width
            $error("IN_W must equal OUT_W*BEATS");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_e;

    state_e                        state_q, state_d;
    logic [BEATS-1:0][OUT_W-1:0]   hold_q, hold_d;
    logic [BEAT_CW-1:0]            beat_cnt_q, beat_cnt_d;
    logic [WORD_CW-1:0]            word_cnt_q, word_cnt_d;
    logic [IN_W-1:0]               relu_word;
    logic                          last_beat;
    logic                          last_word;
    logic                          out_hs;
    logic                          in_hs;

    // Per-lane ReLU on the incoming word; pass-through when disabled.
    always_comb begin
        relu_word = d_Data_TDATA;
        if (RELU_EN != 0) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (d_Data_TDATA[k*LANE_W + LANE_W - 1]) begin
                    relu_word[k*LANE_W +: LANE_W] = '0;
                end
            end
        end
    end

    assign last_beat = (beat_cnt_q == BEAT_CW'(BEATS - 1));
    assign last_word = (word_cnt_q == WORD_CW'(WORDS_PER_FRAME - 1));
    assign out_hs    = (state_q == SEND) && feature_TREADY;

    // Ready as the last beat leaves so the next word loads without a bubble.
    assign d_Data_TREADY = !ap_rst && ((state_q == EMPTY) || (last_beat && feature_TREADY));
    assign in_hs         = d_Data_TVALID && d_Data_TREADY;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        beat_cnt_d = beat_cnt_q;
        word_cnt_d = word_cnt_q;
        if (out_hs) begin
            if (!last_beat) begin
                beat_cnt_d = beat_cnt_q + BEAT_CW'(1);
            end else begin
                word_cnt_d = last_word ? '0 : word_cnt_q + WORD_CW'(1);
                state_d    = EMPTY;
            end
        end
        if (in_hs) begin
            hold_d     = relu_word;
            beat_cnt_d = '0;
            state_d    = SEND;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= EMPTY;
            hold_q     <= '0;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            beat_cnt_q <= beat_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign feature_TVALID = (state_q == SEND);
    assign feature_TDATA  = hold_q[beat_cnt_q];
    assign feature_TLAST  = (state_q == SEND) && last_beat && last_word;

endmodule

// File: tb/tb_layer2_output_serializer.sv
// Bench for layer2_output_serializer: two instances (plain / ReLU with short
// frames) share stimulus and are compared against a beat-queue reference model.
module tb_layer2_output_serializer;

    logic         ap_clk = 1'b0;
    logic         ap_rst;
    logic [511:0] d_Data_TDATA;
    logic         d_Data_TVALID;
    logic         feature_TREADY;

    logic         rdy0, rdy1, vld0, vld1, last0, last1;
    logic [63:0]  dat0, dat1;

    always #5 ap_clk = ~ap_clk;

    layer2_output_serializer #(.WORDS_PER_FRAME(3), .RELU_EN(0)) dut0 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .d_Data_TDATA(d_Data_TDATA), .d_Data_TVALID(d_Data_TVALID), .d_Data_TREADY(rdy0),
        .feature_TDATA(dat0), .feature_TVALID(vld0), .feature_TREADY(feature_TREADY),
        .feature_TLAST(last0)
    );

    layer2_output_serializer #(.WORDS_PER_FRAME(2), .RELU_EN(1)) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .d_Data_TDATA(d_Data_TDATA), .d_Data_TVALID(d_Data_TVALID), .d_Data_TREADY(rdy1),
        .feature_TDATA(dat1), .feature_TVALID(vld1), .feature_TREADY(feature_TREADY),
        .feature_TLAST(last1)
    );

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    wc0 = 0;
    int    wc1 = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    last_in_hs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Enqueue the 8 expected beats of an accepted word for each instance.
    task automatic push_word(input logic [511:0] w);
        logic [511:0] r;
        beat_t b;
        r = w;
        for (int k = 0; k < 32; k++) begin
            if (w[16*k+15]) r[16*k +: 16] = 16'h0000;
        end
        for (int i = 0; i < 8; i++) begin
            b.d = w[64*i +: 64];
            b.l = (i == 7) && (wc0 == 2);
            q0.push_back(b);
            b.d = r[64*i +: 64];
            b.l = (i == 7) && (wc1 == 1);
            q1.push_back(b);
        end
        wc0 = (wc0 + 1) % 3;
        wc1 = (wc1 + 1) % 2;
    endtask

    task automatic cycle(input logic rst, input logic iv, input logic [511:0] id, input logic ordy);
        logic exp_rdy;
        logic out_hs;
        ap_rst         = rst;
        d_Data_TVALID  = iv;
        d_Data_TDATA   = id;
        feature_TREADY = ordy;
        @(negedge ap_clk);
        exp_rdy = !rst && ((q0.size() == 0) || ((q0.size() == 1) && ordy));
        check("in_ready0", 64'(rdy0), 64'(exp_rdy));
        check("in_ready1", 64'(rdy1), 64'(exp_rdy));
        check("valid0", 64'(vld0), 64'(q0.size() != 0));
        check("valid1", 64'(vld1), 64'(q1.size() != 0));
        if (q0.size() != 0) begin
            check("data0", dat0, q0[0].d);
            check("last0", 64'(last0), 64'(q0[0].l));
        end else begin
            check("last0_idle", 64'(last0), 64'd0);
        end
        if (q1.size() != 0) begin
            check("data1", dat1, q1[0].d);
            check("last1", 64'(last1), 64'(q1[0].l));
        end else begin
            check("last1_idle", 64'(last1), 64'd0);
        end
        last_in_hs = iv && exp_rdy;
        out_hs     = !rst && (q0.size() != 0) && ordy;
        @(posedge ap_clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            wc0 = 0;
            wc1 = 0;
        end else begin
            if (out_hs) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (last_in_hs) push_word(id);
        end
        #1;
    endtask

    function automatic logic [511:0] rand_word();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    logic [511:0] lane_word;
    logic [511:0] cur;
    logic         iv_r;
    logic         ordy_r;
    logic [3:0]   stall_pat;

    initial begin
        for (int k = 0; k < 32; k++) lane_word[16*k +: 16] = 16'(k);
        ap_rst         = 1'b1;
        d_Data_TVALID  = 1'b0;
        d_Data_TDATA   = '0;
        feature_TREADY = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        check("reset_data0", dat0, 64'd0);
        check("reset_data1", dat1, 64'd0);

        // Single lane-indexed word drained at full rate.
        cycle(1'b0, 1'b1, lane_word, 1'b1);
        check("t1_beat0_const", dat0, 64'h0003_0002_0001_0000);
        repeat (10) cycle(1'b0, 1'b0, '0, 1'b1);

        // Back-to-back words with continuous ready.
        cur = rand_word();
        repeat (30) begin
            cycle(1'b0, 1'b1, cur, 1'b1);
            if (last_in_hs) cur = rand_word();
        end

        // Ready pattern 1,0,0,1 while streaming.
        stall_pat = 4'b1001;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b0, 1'b1, cur, stall_pat[c % 4]);
            if (last_in_hs) cur = rand_word();
        end
        repeat (40) cycle(1'b0, 1'b0, '0, 1'b1);

        // ReLU boundary lanes.
        cur = lane_word;
        cur[15:0]  = 16'h8001;
        cur[31:16] = 16'h7FFF;
        cycle(1'b0, 1'b1, cur, 1'b1);
        check("relu_lane0", 64'(dat1[15:0]), 64'h0000);
        check("relu_lane1", 64'(dat1[31:16]), 64'h7FFF);
        repeat (10) cycle(1'b0, 1'b0, '0, 1'b1);

        // Reset during beat 4 of the fourth word, then restart a frame.
        cycle(1'b1, 1'b0, '0, 1'b1);
        cur = rand_word();
        for (int c = 0; c < 29; c++) begin
            cycle(1'b0, 1'b1, cur, 1'b1);
            if (last_in_hs) cur = rand_word();
        end
        cycle(1'b1, 1'b1, cur, 1'b1);
        check("rst_valid0", 64'(vld0), 64'd0);
        check("rst_last0", 64'(last0), 64'd0);
        for (int c = 0; c < 30; c++) begin
            cycle(1'b0, 1'b1, cur, 1'b1);
            if (last_in_hs) cur = rand_word();
        end

        // Randomized traffic with occasional reset; upstream holds unaccepted words.
        iv_r = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!iv_r) begin
                iv_r = ($urandom_range(3, 0) != 0);
                cur  = rand_word();
                if ($urandom_range(3, 0) == 0) cur[15] = 1'b1;
            end
            ordy_r = ($urandom_range(3, 0) != 0);
            cycle(($urandom_range(99, 0) == 0), iv_r, cur, ordy_r);
            if (last_in_hs || ap_rst) iv_r = 1'b0;
        end
        repeat (20) cycle(1'b0, 1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
